kernel_launcher: RTL

KERNEL_LAUNCHER -- requirements
Module: kernel_launcher

---
 rtl/kernel_launcher_pkg.sv | 17 +
 rtl/launch_timer.sv | 35 +++
 rtl/kernel_launcher.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/kernel_launcher_pkg.sv
// Shared definitions for the kernel launcher: FSM state encoding and the
// default sizing constants used as parameter defaults by the top level.
package kernel_launcher_pkg;

  localparam int DEF_CYCLE_BITS     = 16;
  localparam int DEF_RESET_CYCLES   = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GPU_RST = 3'd1,
    ST_DCR_WR  = 3'd2,
    ST_RUN     = 3'd3,
    ST_REPORT  = 3'd4
  } state_t;

endpackage

// File: rtl/launch_timer.sv
// Saturating cycle timer shared by the GPU reset hold and the RUN count.
// Clear has priority over enable; o_tc compares the current count against
// the terminal value chosen by the caller; o_count_inc is the value the
// counter takes on the next enabled cycle (already saturated).
module launch_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_terminal,
  output logic [W-1:0] o_count_inc,
  output logic         o_tc
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max    = &r_count;
  assign o_count_inc = w_at_max ? r_count : r_count + W'(1);
  assign o_tc        = (r_count == i_terminal);

  // Counter: clear on phase entry, count while enabled, never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_count_inc;
    end
  end

endmodule

// File: rtl/kernel_launcher.sv
// Kernel launcher: accepts a host launch, pulses GPU reset, writes the thread
// count to the DCR, runs the kernel and reports the RUN cycle count.
// Optional abort-on-timeout is compiled in with KERNEL_LAUNCHER_TIMEOUT_EN.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid stays asserted with stable payload until that edge.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int CYCLE_BITS     = DEF_CYCLE_BITS,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  input  logic [7:0]            launch_thread_count,
  output logic                  gpu_reset,
  output logic                  device_control_write_enable,
  output logic [7:0]            device_control_data,
  output logic                  gpu_start,
  input  logic                  gpu_done,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [CYCLE_BITS-1:0] result_cycles,
  output logic                  result_timeout,
  output logic                  busy,
  output state_t                dbg_state
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_launch_ready;
  logic                  r_busy;
  logic                  r_gpu_reset;
  logic                  r_dcr_we;
  logic [7:0]            r_dcr_data;
  logic                  r_gpu_start;
  logic                  r_result_valid;
  logic [7:0]            r_thread_count;
  logic [CYCLE_BITS-1:0] r_result_cycles;
  logic                  w_accept;
  logic                  w_timer_clear;
  logic                  w_timer_en;
  logic [CYCLE_BITS-1:0] w_terminal;
  logic [CYCLE_BITS-1:0] w_count_inc;
  logic                  w_tc;
  logic                  w_timeout;
  logic                  w_abort;

  assign w_accept      = launch_valid && r_launch_ready;
  assign w_timer_en    = (r_state == ST_GPU_RST) || (r_state == ST_RUN);
  assign w_timer_clear = (w_state_next != r_state) &&
                         ((w_state_next == ST_GPU_RST) || (w_state_next == ST_RUN));
  // Terminal count is RESET_CYCLES-1 / TIMEOUT_CYCLES-1 because the compare
  // sees the count before the increment of the current cycle.
  assign w_terminal    = (r_state == ST_GPU_RST) ? CYCLE_BITS'(RESET_CYCLES - 1)
                                                 : CYCLE_BITS'(TIMEOUT_CYCLES - 1);

  launch_timer #(.W(CYCLE_BITS)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_timer_clear),
    .i_enable    (w_timer_en),
    .i_terminal  (w_terminal),
    .o_count_inc (w_count_inc),
    .o_tc        (w_tc)
  );

`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
  logic r_abort;
  logic r_result_timeout;

  assign w_timeout      = w_tc;
  assign w_abort        = r_abort;
  assign result_timeout = r_result_timeout;

  // Abort bookkeeping: mark a timed-out launch, flag it on entry to REPORT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_abort          <= 1'b0;
      r_result_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_abort          <= 1'b0;
        r_result_timeout <= 1'b0;
      end else if ((r_state == ST_RUN) && (w_state_next == ST_GPU_RST)) begin
        r_abort <= 1'b1;
      end else if ((r_state == ST_GPU_RST) && (w_state_next == ST_REPORT)) begin
        r_result_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_timeout      = 1'b0;
  assign w_abort        = 1'b0;
  assign result_timeout = 1'b0;
`endif

  // Next-state decode; gpu_done is only looked at in RUN and beats timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_next = (launch_thread_count != 8'd0) ? ST_GPU_RST : ST_REPORT;
      ST_GPU_RST: if (w_tc) w_state_next = w_abort ? ST_REPORT : ST_DCR_WR;
      ST_DCR_WR:  w_state_next = ST_RUN;
      ST_RUN: begin
        if (gpu_done)       w_state_next = ST_REPORT;
        else if (w_timeout) w_state_next = ST_GPU_RST;
      end
      ST_REPORT:  if (result_ready) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_launch_ready  <= 1'b0;
      r_busy          <= 1'b0;
      r_gpu_reset     <= 1'b1;
      r_dcr_we        <= 1'b0;
      r_dcr_data      <= 8'd0;
      r_gpu_start     <= 1'b0;
      r_result_valid  <= 1'b0;
      r_thread_count  <= 8'd0;
      r_result_cycles <= '0;
    end else begin
      r_state        <= w_state_next;
      r_launch_ready <= (w_state_next == ST_IDLE);
      r_busy         <= (w_state_next != ST_IDLE);
      r_gpu_reset    <= (w_state_next == ST_GPU_RST);
      r_dcr_we       <= (w_state_next == ST_DCR_WR);
      r_dcr_data     <= (w_state_next == ST_DCR_WR) ? r_thread_count : 8'd0;
      r_gpu_start    <= (w_state_next == ST_RUN);
      r_result_valid <= (w_state_next == ST_REPORT);
      if (w_accept) begin
        r_thread_count  <= launch_thread_count;
        r_result_cycles <= '0;
      end else if ((r_state == ST_RUN) && (w_state_next != ST_RUN)) begin
        r_result_cycles <= w_count_inc;
      end
    end
  end

  assign launch_ready                = r_launch_ready;
  assign busy                        = r_busy;
  assign gpu_reset                   = r_gpu_reset;
  assign device_control_write_enable = r_dcr_we;
  assign device_control_data         = r_dcr_data;
  assign gpu_start                   = r_gpu_start;
  assign result_valid                = r_result_valid;
  assign result_cycles               = r_result_cycles;
  assign dbg_state                   = r_state;

endmodule
